// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the register-bank bus transfer sequencer:
// state encoding and the bus release value.
package bus_xfer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        XFER  = 3'd2,
        REL   = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Wide enough for any supported data width; users slice the low bits.
    localparam int                   BUS_MAX_W   = 64;
    localparam logic [BUS_MAX_W-1:0] BUS_RELEASE = {BUS_MAX_W{1'bz}};

endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// Request/status bundle between a transfer requester and bus_transfer_ctrl.
// The shared data bus itself stays a plain inout on the controller.
interface bus_transfer_ctrl_if #(
    parameter int p_data_width = 8,
    parameter int p_num_regs   = 4,
    parameter int p_sel_width  = 2
);

    logic                    i_w_start;
    logic [p_sel_width-1:0]  i_w_src;
    logic [p_sel_width-1:0]  i_w_dst;
    logic                    i_w_imm_en;
    logic [p_data_width-1:0] i_w_imm;
    logic [p_num_regs-1:0]   o_w_oe;
    logic [p_num_regs-1:0]   o_w_we;
    logic                    o_w_busy;
    logic                    o_w_done;
    logic                    o_w_err;
    logic [p_data_width-1:0] o_w_data;

    modport master (
        output i_w_start, i_w_src, i_w_dst, i_w_imm_en, i_w_imm,
        input  o_w_oe, o_w_we, o_w_busy, o_w_done, o_w_err, o_w_data
    );

    modport slave (
        input  i_w_start, i_w_src, i_w_dst, i_w_imm_en, i_w_imm,
        output o_w_oe, o_w_we, o_w_busy, o_w_done, o_w_err, o_w_data
    );

endinterface

// File: rtl/bus_transfer_ctrl_sel_decoder.sv
// Index-to-one-hot decoder; an out-of-range index or a low enable gives all zeros.
module sel_decoder #(
    parameter int p_sel_width = 2,
    parameter int p_num_regs  = 4
) (
    input  logic [p_sel_width-1:0] sel,
    input  logic                   en,
    output logic [p_num_regs-1:0]  onehot
);

    for (genvar gi = 0; gi < p_num_regs; gi++) begin : g_bit
        assign onehot[gi] = en && (sel == p_sel_width'(gi));
    end

endmodule

// File: rtl/register.sv
// Bus-attached storage register: drives the bus when output-enabled,
// latches it when write-enabled; both at once is ignored for the write.
module register #(
    parameter int p_data_width = 8
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic                    i_w_oe,
    input  logic                    i_w_we,
    inout  wire  [p_data_width-1:0] io_w_bus,
    output logic [p_data_width-1:0] o_w_data
);

    logic [p_data_width-1:0] data_reg;

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            data_reg <= '0;
        end else if (i_w_we && !i_w_oe) begin
            data_reg <= io_w_bus;
        end
    end

    assign io_w_bus = i_w_oe ? data_reg : {p_data_width{1'bz}};
    assign o_w_data = data_reg;

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Sequences one register-to-register move or immediate load on the shared
// tri-state bus: drive, then write, then release, with all enables registered.
module bus_transfer_ctrl
    import bus_xfer_pkg::*;
#(
    parameter int p_data_width = 8,
    parameter int p_num_regs   = 4,
    parameter int p_sel_width  = 2
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    bus_transfer_ctrl_if.slave      ctrl,
    inout  wire  [p_data_width-1:0] io_w_bus
);

    state_t                  state_reg;
    state_t                  state_next;

    logic [p_sel_width-1:0]  src_reg;
    logic [p_sel_width-1:0]  dst_reg;
    logic                    imm_en_reg;
    logic [p_data_width-1:0] imm_reg;
    logic [p_data_width-1:0] data_reg;

    logic [p_num_regs-1:0]   oe_reg;
    logic [p_num_regs-1:0]   we_reg;
    logic                    drive_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    err_reg;

    logic [p_sel_width-1:0]  src_cur;
    logic [p_sel_width-1:0]  dst_cur;
    logic                    imm_en_cur;
    logic                    req_valid;
    logic                    oe_en_next;
    logic                    we_en_next;
    logic                    drive_next;
    logic [p_num_regs-1:0]   oe_next;
    logic [p_num_regs-1:0]   we_next;

    // In IDLE the request is still on the inputs; afterwards use the latched copy.
    always_comb begin
        src_cur    = src_reg;
        dst_cur    = dst_reg;
        imm_en_cur = imm_en_reg;
        if (state_reg == IDLE) begin
            src_cur    = ctrl.i_w_src;
            dst_cur    = ctrl.i_w_dst;
            imm_en_cur = ctrl.i_w_imm_en;
        end
    end

    assign req_valid = (int'(ctrl.i_w_dst) < p_num_regs) &&
                       (ctrl.i_w_imm_en ||
                        ((int'(ctrl.i_w_src) < p_num_regs) && (ctrl.i_w_src != ctrl.i_w_dst)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ctrl.i_w_start) state_next = req_valid ? DRIVE : ERR;
            DRIVE:   state_next = XFER;
            XFER:    state_next = REL;
            REL:     state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        oe_en_next = ((state_next == DRIVE) || (state_next == XFER)) && !imm_en_cur;
        drive_next = ((state_next == DRIVE) || (state_next == XFER)) && imm_en_cur;
        we_en_next = (state_next == XFER);
    end

    sel_decoder #(
        .p_sel_width (p_sel_width),
        .p_num_regs  (p_num_regs)
    ) u_oe_dec (
        .sel    (src_cur),
        .en     (oe_en_next),
        .onehot (oe_next)
    );

    sel_decoder #(
        .p_sel_width (p_sel_width),
        .p_num_regs  (p_num_regs)
    ) u_we_dec (
        .sel    (dst_cur),
        .en     (we_en_next),
        .onehot (we_next)
    );

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_reg  <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            imm_en_reg <= 1'b0;
            imm_reg    <= '0;
            data_reg   <= '0;
            oe_reg     <= '0;
            we_reg     <= '0;
            drive_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            oe_reg    <= oe_next;
            we_reg    <= we_next;
            drive_reg <= drive_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == REL);
            err_reg   <= (state_next == ERR);
            if ((state_reg == IDLE) && ctrl.i_w_start) begin
                src_reg    <= ctrl.i_w_src;
                dst_reg    <= ctrl.i_w_dst;
                imm_en_reg <= ctrl.i_w_imm_en;
                imm_reg    <= ctrl.i_w_imm;
            end
            // Same edge at which the destination register samples the bus.
            if (state_reg == XFER) begin
                data_reg <= imm_en_reg ? imm_reg : io_w_bus;
            end
        end
    end

    assign io_w_bus      = drive_reg ? imm_reg : BUS_RELEASE[p_data_width-1:0];

    assign ctrl.o_w_oe   = oe_reg;
    assign ctrl.o_w_we   = we_reg;
    assign ctrl.o_w_busy = busy_reg;
    assign ctrl.o_w_done = done_reg;
    assign ctrl.o_w_err  = err_reg;
    assign ctrl.o_w_data = data_reg;

endmodule

// File: doc/bus_transfer_ctrl.md
Name: bus_transfer_ctrl

Overview:
- Sequencer for the shared tri-state data bus that connects a bank of `register` instances.
- On a start request it performs one register-to-register move (or an immediate load) by driving the per-register output-enable and write-enable lines in a safe, glitch-free order.
- It also captures the transferred value for display.
- Sits directly upstream of the register bank; its o_w_oe/o_w_we bits wire one-to-one to each register's i_w_oe/i_w_we.

Parameters:
- p_data_width, 8, bus and register data width.
- p_num_regs, 4, number of registers on the bus (2..16).
- p_sel_width, 2, width of source/destination select; must satisfy 2**p_sel_width >= p_num_regs.

Ports:
- i_w_clk  input  1  clock.
- i_w_reset  input  1  asynchronous, active-low reset.
- i_w_start  input  1  transfer request, sampled only in IDLE.
- i_w_src  input  p_sel_width  source register index (ignored when i_w_imm_en=1).
- i_w_dst  input  p_sel_width  destination register index.
- i_w_imm_en  input  1  1 = load i_w_imm instead of reading a register.
- i_w_imm  input  p_data_width  immediate value.
- o_w_oe  output  p_num_regs  one-hot output-enable to registers.
- o_w_we  output  p_num_regs  one-hot write-enable to registers.
- io_w_bus  inout  p_data_width  shared bus; driven by this block only during immediate loads.
- o_w_busy  output  1  high from the cycle after start is accepted until back in IDLE.
- o_w_done  output  1  one-cycle pulse on successful completion.
- o_w_err  output  1  one-cycle pulse on a rejected request.
- o_w_data  output  p_data_width  last value written, held until the next successful transfer.

Behaviour:
- Reset (asynchronous, i_w_reset=0), effective immediately regardless of state:
  - state=IDLE; o_w_oe=0, o_w_we=0, o_w_busy=0, o_w_done=0, o_w_err=0, o_w_data=0.
  - io_w_bus released to all-z.
- Request latching: in IDLE, i_w_start=1 at a rising edge latches src, dst, imm_en and imm into internal registers. Inputs may change afterwards without effect.
- Validation, performed at the accepting edge:
  - Reject if dst >= p_num_regs.
  - Reject if imm_en=0 and src >= p_num_regs.
  - Reject if imm_en=0 and src==dst.
  - On reject: go to ERR instead of DRIVE.
- States (one-hot or binary; encoding lives in the package):
  - IDLE:
    - All enables 0, bus released.
    - Valid start goes to DRIVE; invalid start goes to ERR.
  - DRIVE (1 cycle):
    - Register source: o_w_oe[src]=1.
    - Immediate: io_w_bus=imm.
    - o_w_we=0, so the bus settles before any write. Next state is XFER.
  - XFER (1 cycle):
    - Source drive is held as in DRIVE; o_w_we[dst]=1.
    - For the immediate case, o_w_oe stays all-zero.
    - At the closing edge the destination register latches the bus and o_w_data<=io_w_bus. Next state is REL.
  - REL (1 cycle):
    - All enables 0 and bus released; o_w_done=1. Next state is IDLE.
  - ERR (1 cycle):
    - All enables 0; o_w_err=1; o_w_data unchanged. Next state is IDLE.
- Invariants:
  - Never assert o_w_oe[k] and o_w_we[k] together for the same k; the register ignores that combination.
  - At most one o_w_oe bit is set at any time.
  - At most one o_w_we bit is set at any time.
  - This block never drives io_w_bus while any o_w_oe bit is set.
- o_w_busy=1 in DRIVE, XFER, REL and ERR.
- Latency: start accepted at edge N; the destination is written at edge N+2; o_w_done is high during cycle N+3. Throughput is one transfer per 4 cycles.
- Back-to-back requests: i_w_start held high re-triggers from IDLE on the edge after REL/ERR. Start while busy is ignored, not queued.
- Reset mid-transfer: enables drop asynchronously; the destination may or may not have been written (it is written only if the XFER closing edge was reached).
- All enables and the bus-drive enable come from registered state, never combinationally from inputs.

Decomposition:
- Package bus_xfer_pkg holds:
  - state encoding constants: IDLE, DRIVE, XFER, REL, ERR;
  - state width constant;
  - bus release constant (all-z of p_data_width).
- One sub-module, sel_decoder: p_sel_width index plus enable to a p_num_regs one-hot vector. Instantiate it twice, once for oe and once for we.
- The bench instantiates 4 `register` instances on io_w_bus.

Test Plan:
- Immediate load: imm_en=1, imm=8'hA5, dst=2, start pulse. Expected:
  - o_w_oe=0 throughout; o_w_we=4'b0100 only in XFER;
  - reg2 display=A5 after edge N+2; o_w_done pulse at N+3; o_w_data=A5.
- Register move: preload R1=3C, then src=1, dst=3. Expected:
  - o_w_oe=4'b0010 in DRIVE and XFER; o_w_we=4'b1000 in XFER only;
  - R3=3C; R1 still 3C; no bus contention (no x on bus).
- Rejects:
  - src=2, dst=2, imm_en=0 -> o_w_err pulse one cycle after start; no enable ever set; o_w_data unchanged.
  - dst=3 with p_num_regs=3 -> same error response.
- Busy handling: start held high for 10 cycles with valid move 0->1. Expected:
  - transfers at 4-cycle spacing; done pulses on cycles 3 and 7;
  - mid-transfer changes of src/dst have no effect.
- Reset mid-XFER: assert i_w_reset=0 asynchronously between edges. Expected:
  - o_w_oe, o_w_we and o_w_busy go 0 before the next edge; io_w_bus is z;
  - after release the FSM is in IDLE and accepts a new start.
- Invariant checker for all tests: for every k, never o_w_oe[k]&&o_w_we[k]; $onehot0 on o_w_oe and o_w_we; bus driven by at most one source.
